ex_core_rom_bist: RTL

- Parametrised, registered successor to the example-core identity ROM used behind the IEEE 1500 wrapper.
- Content is generated, not stored: word[a] = a (zero-extended or truncated to DATA_W) XOR CONTENT_SEED.
- Adds a valid/ready read port with one-cycle latency.
- Adds a built-in self-test that sweeps all DEPTH words through a MISR and flags pass/fail against an expected signature, so the wrapper's test controller can launch it.

---
 rtl/ex_rom_pkg.sv | 36 +++
 rtl/ex_rom_misr.sv | 39 +++
 rtl/ex_core_rom_bist.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ex_rom_pkg.sv
// rtl/ex_rom_pkg.sv - shared types and pure helpers for the generated-content ROM with BIST
//
// Purpose : FSM state type, generated ROM word function and MISR step function.
//           Helpers work on MAX_W-bit vectors; callers truncate the result to
//           their own DATA_W, which also gives the zero-extend/truncate rule
//           for rom_word.
// Ports   : none (package)
package ex_rom_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } bist_state_e;

  function automatic logic [MAX_W-1:0] rom_word(input logic [MAX_W-1:0] addr,
                                                input logic [MAX_W-1:0] seed);
    return addr ^ seed;
  endfunction

  // Shift left, fold the outgoing MSB (bit width-1) back through the
  // polynomial, then absorb the new data word. Bits at and above width are junk.
  function automatic logic [MAX_W-1:0] misr_step(input logic [MAX_W-1:0] sig,
                                                 input logic [MAX_W-1:0] data,
                                                 input logic [MAX_W-1:0] poly,
                                                 input int               width);
    logic [MAX_W-1:0] r;
    r = (sig << 1) ^ data;
    if (sig[width-1]) r = r ^ poly;
    return r;
  endfunction

endpackage

// File: rtl/ex_rom_misr.sv
// rtl/ex_rom_misr.sv - DATA_W-bit multiple-input signature register
//
// Purpose : Compacts one data word per enabled cycle into a signature.
//           clear has priority over enable.
// Ports   : clk    in  core clock
//           rst_n  in  asynchronous active-low reset
//           clear  in  synchronous clear to zero
//           enable in  absorb data this cycle
//           data   in  DATA_W word to absorb
//           sig    out current signature
module ex_rom_misr
  import ex_rom_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] POLY   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] sig
);

  logic [DATA_W-1:0] r_sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (clear) begin
      r_sig <= '0;
    end else if (enable) begin
      r_sig <= DATA_W'(misr_step(MAX_W'(r_sig), MAX_W'(data), MAX_W'(POLY), DATA_W));
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/ex_core_rom_bist.sv
// rtl/ex_core_rom_bist.sv - registered identity ROM with valid/ready read port and MISR self-test
//
// Purpose : word[a] = a ^ CONTENT_SEED (DATA_W bits). One-cycle-latency read
//           port; BIST sweeps all DEPTH words through a MISR and compares the
//           result against EXPECTED_SIG.
// Macro   : EX_ROM_FAULT_INJECT_EN adds port fault_inj and parameter FAULT_ADDR;
//           while fault_inj=1, bit 0 of word[FAULT_ADDR] is inverted.
// Ports   : clk        in  core clock
//           rst_n      in  asynchronous active-low reset
//           rd_req     in  read request
//           rd_addr    in  read address, sampled on accept
//           rd_ready   out read port can accept (combinational)
//           rd_valid   out one-cycle pulse, rd_data valid
//           rd_data    out read data, held between responses
//           rd_err     out pulses with rd_valid for out-of-range address
//           bist_start in  start or restart self-test
//           bist_busy  out self-test in progress
//           bist_done  out self-test finished, held
//           bist_pass  out signature matched, held with bist_done
//           bist_sig   out live MISR signature
//           fault_inj  in  (macro only) invert bit 0 of word[FAULT_ADDR]
module ex_core_rom_bist
  import ex_rom_pkg::*;
#(
  parameter int                ADDR_W       = 8,
  parameter int                DATA_W       = 8,
  parameter int                DEPTH        = 256,
  parameter logic [DATA_W-1:0] CONTENT_SEED = '0,
  parameter logic [DATA_W-1:0] MISR_POLY    = DATA_W'(8'h1D),
  parameter logic [DATA_W-1:0] EXPECTED_SIG = '0
`ifdef EX_ROM_FAULT_INJECT_EN
  ,
  parameter int                FAULT_ADDR   = 0
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  input  logic              bist_start,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_pass,
  output logic [DATA_W-1:0] bist_sig
`ifdef EX_ROM_FAULT_INJECT_EN
  ,
  input  logic              fault_inj
`endif
);

  // One extra counter bit so DEPTH == 2**ADDR_W never wraps.
  localparam int             CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);
`ifdef EX_ROM_FAULT_INJECT_EN
  localparam logic [CNT_W-1:0] FAULT_C = CNT_W'(FAULT_ADDR);
`endif

  bist_state_e       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_rd_valid;
  logic              r_rd_err;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_idle_like;
  logic              w_launch;
  logic              w_rd_ready;
  logic              w_accept;
  logic              w_rd_oor;
  logic [CNT_W-1:0]  w_rd_addr_x;
  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0] w_bist_word;
  logic [DATA_W-1:0] w_sig;

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_launch    = w_idle_like && bist_start;
  // Gated by rst_n so every output reads 0 while reset is held.
  assign w_rd_ready  = rst_n && w_idle_like && !bist_start;
  assign w_accept    = rd_req && w_rd_ready;
  assign w_rd_addr_x = {1'b0, rd_addr};
  assign w_rd_oor    = w_rd_addr_x >= DEPTH_C;

  always_comb begin
    w_rd_word   = DATA_W'(rom_word(MAX_W'(w_rd_addr_x), MAX_W'(CONTENT_SEED)));
    w_bist_word = DATA_W'(rom_word(MAX_W'(r_cnt), MAX_W'(CONTENT_SEED)));
`ifdef EX_ROM_FAULT_INJECT_EN
    if (fault_inj && (w_rd_addr_x == FAULT_C)) w_rd_word[0]   = ~w_rd_word[0];
    if (fault_inj && (r_cnt == FAULT_C))       w_bist_word[0] = ~w_bist_word[0];
`endif
  end

  ex_rom_misr #(
    .DATA_W (DATA_W),
    .POLY   (MISR_POLY)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_launch),
    .enable (r_state == ST_RUN),
    .data   (w_bist_word),
    .sig    (w_sig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bist_start) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_C) r_state <= ST_CMP;
        end
        ST_CMP: begin
          // MISR already holds the word[DEPTH-1] update here.
          r_pass  <= (w_sig == EXPECTED_SIG);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_accept;
      r_rd_err   <= w_accept && w_rd_oor;
      if (w_accept) r_rd_data <= w_rd_oor ? '0 : w_rd_word;
    end
  end

  assign rd_ready  = w_rd_ready;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rd_err    = r_rd_err;
  assign bist_busy = r_busy;
  assign bist_done = r_done;
  assign bist_pass = r_pass;
  assign bist_sig  = w_sig;

endmodule
